pulse_period_checker: RTL and testbench

Receive-side companion to the clock-divider FSMs. Samples a one-cycle-wide periodic pulse train, such as a divide-by-N tick, and measures the number of `clk` cycles between successive pulses. It declares lock after a run of periods equal to the programmed expectation, then monitors for early, late or missing pulses. It sits downstream of any divider/tick generator as its self-check and lock indicator.

---
 rtl/pulse_chk_pkg.sv | 23 ++
 rtl/period_counter.sv | 40 ++++
 rtl/pulse_period_checker.sv | 177 +++++++++++++++++
 tb/tb_pulse_period_checker.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/pulse_chk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pulse_chk_pkg
// Description : Shared types for the pulse period checker: FSM state encoding
//               and the width of the optional loss counter.
// Revision    : 1.0 - initial release
// ============================================================================
package pulse_chk_pkg;

  // Checker FSM states, explicitly encoded on three bits
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_FIRST = 3'd1,
    MEASURE    = 3'd2,
    LOCKED     = 3'd3,
    LOST       = 3'd4
  } statetype;

  // Width of the saturating loss-of-lock counter
  localparam int LOSS_W = 8;

endpackage : pulse_chk_pkg
`default_nettype wire

// File: rtl/period_counter.sv
`default_nettype none
// ============================================================================
// Module      : period_counter
// Description : CNT_W-bit saturating up-counter with synchronous clear.
//               o_sat is high while the count sits at its maximum value.
// Revision    : 1.0 - initial release
// ============================================================================
module period_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_sat
);

  localparam logic [CNT_W-1:0] C_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] r_cnt;
  logic             w_sat;

  assign w_sat = (r_cnt == C_MAX);

  // Count every cycle unless cleared; hold once the maximum is reached
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (!w_sat) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt = r_cnt;
  assign o_sat = w_sat;

endmodule : period_counter
`default_nettype wire

// File: rtl/pulse_period_checker.sv
`default_nettype none
// ============================================================================
// Module      : pulse_period_checker
// Description : Measures the spacing of a one-cycle periodic pulse train,
//               declares lock after LOCK_COUNT consecutive periods equal to
//               exp_period, then flags early or missing pulses with a sticky
//               err. Optional feature macro PULSE_CHK_STATS_EN adds the
//               loss_count output (saturating count of lock losses).
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_period_checker
  import pulse_chk_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int LOCK_COUNT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             pulse_in,
  input  logic [CNT_W-1:0] exp_period,
  input  logic             err_clr,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             err
`ifdef PULSE_CHK_STATS_EN
  ,
  output logic [LOSS_W-1:0] loss_count
`endif
);

  localparam int               MCNT_W = $clog2(LOCK_COUNT + 1);
  localparam logic [MCNT_W-1:0] C_LOCK = MCNT_W'(LOCK_COUNT);
  localparam logic [CNT_W-1:0]  C_MAX  = {CNT_W{1'b1}};

  statetype          r_state;
  statetype          w_state_next;
  logic [CNT_W-1:0]  w_cnt;
  logic              w_sat;
  logic              w_cnt_clr;
  logic [CNT_W-1:0]  w_meas;
  logic              w_match;
  logic [MCNT_W-1:0] r_mcnt;
  logic [MCNT_W-1:0] w_mcnt_inc;
  logic [MCNT_W-1:0] w_mcnt_next;
  logic              w_strobe;
  logic              w_loss;
  logic [CNT_W-1:0]  r_period;
  logic              r_period_valid;
  logic              r_locked;
  logic              r_err;

  // Counter restarts on every event and is held at zero while idle/disabled
  assign w_cnt_clr = !en || (r_state == IDLE) || pulse_in;

  period_counter #(
    .CNT_W (CNT_W)
  ) u_period_counter (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_cnt_clr),
    .o_cnt (w_cnt),
    .o_sat (w_sat)
  );

  // Period as it would be measured if an event landed this cycle; a
  // saturated counter reports the largest representable period.
  assign w_meas     = w_sat ? C_MAX : (w_cnt + CNT_W'(1));
  assign w_match    = (w_meas == exp_period);
  assign w_mcnt_inc = r_mcnt + MCNT_W'(1);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decision
  always_comb begin
    w_state_next = r_state;
    if (!en) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE:       w_state_next = WAIT_FIRST;
        WAIT_FIRST: if (pulse_in) w_state_next = MEASURE;
        MEASURE: begin
          if (pulse_in) begin
            if (w_match && (w_mcnt_inc == C_LOCK)) w_state_next = LOCKED;
          end else if (w_sat) begin
            w_state_next = WAIT_FIRST;
          end
        end
        LOCKED: begin
          // Early pulse (event off-period) or missing pulse (due slot empty)
          if (pulse_in && !w_match)      w_state_next = LOST;
          else if (!pulse_in && w_match) w_state_next = LOST;
        end
        LOST:       if (pulse_in) w_state_next = MEASURE;
        default:    w_state_next = IDLE;
      endcase
    end
  end

  // Output/datapath decode: strobe, match count and lock-loss detection
  always_comb begin
    w_strobe    = en && pulse_in && ((r_state == MEASURE) || (r_state == LOCKED));
    w_loss      = en && (r_state == LOCKED) && (w_state_next == LOST);
    w_mcnt_next = r_mcnt;
    if (!en) begin
      w_mcnt_next = '0;
    end else begin
      case (r_state)
        MEASURE: begin
          if (pulse_in)   w_mcnt_next = w_match ? w_mcnt_inc : '0;
          else if (w_sat) w_mcnt_next = '0;
        end
        LOCKED:  if (w_state_next == LOST) w_mcnt_next = '0;
        default: w_mcnt_next = '0;
      endcase
    end
  end

  // Registered outputs; err and period survive a disable, only reset clears all
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mcnt         <= '0;
      r_period       <= '0;
      r_period_valid <= 1'b0;
      r_locked       <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      r_mcnt         <= w_mcnt_next;
      r_period_valid <= w_strobe;
      r_locked       <= (w_state_next == LOCKED);
      if (w_strobe) begin
        r_period <= w_meas;
      end
      // A new loss takes priority over a simultaneous clear
      if (w_loss) begin
        r_err <= 1'b1;
      end else if (err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  assign period       = r_period;
  assign period_valid = r_period_valid;
  assign locked       = r_locked;
  assign err          = r_err;

`ifdef PULSE_CHK_STATS_EN
  logic [LOSS_W-1:0] r_loss_count;

  // Saturating loss tally; an increment overrides a simultaneous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_loss_count <= '0;
    end else if (w_loss) begin
      if (r_loss_count != {LOSS_W{1'b1}}) begin
        r_loss_count <= r_loss_count + LOSS_W'(1);
      end
    end else if (err_clr) begin
      r_loss_count <= '0;
    end
  end

  assign loss_count = r_loss_count;
`endif

endmodule : pulse_period_checker
`default_nettype wire

// File: tb/tb_pulse_period_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_pulse_period_checker
// Description : Directed testbench for pulse_period_checker. Expected period
//               strobes are queued as pulses are driven; a negedge monitor
//               pops and compares them. Lock/err/reset behaviour is checked
//               at hand-computed points.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse_period_checker;

  localparam int CNT_W = 8;

  logic             clk;
  logic             reset;
  logic             en;
  logic             pulse_in;
  logic [CNT_W-1:0] exp_period;
  logic             err_clr;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             locked;
  logic             err;
`ifdef PULSE_CHK_STATS_EN
  logic [7:0]       loss_count;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int expq[$];

  pulse_period_checker #(
    .CNT_W      (CNT_W),
    .LOCK_COUNT (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .pulse_in     (pulse_in),
    .exp_period   (exp_period),
    .err_clr      (err_clr),
    .period       (period),
    .period_valid (period_valid),
    .locked       (locked),
    .err          (err)
`ifdef PULSE_CHK_STATS_EN
    ,
    .loss_count   (loss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int req);
    n_checks++;
    if (got == req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, got, req);
  endtask

  // One clock cycle with the given pulse level; returns 1 time unit after the edge
  task automatic tick(input logic p);
    pulse_in = p;
    @(posedge clk);
    #1;
    pulse_in = 1'b0;
  endtask

  // n pulses, each preceded by gap-1 idle cycles; first_exp<0 means the
  // first pulse produces no strobe, later pulses strobe with period gap
  task automatic pulses(input int n, input int gap, input int first_exp);
    for (int i = 0; i < n; i++) begin
      repeat (gap - 1) tick(1'b0);
      if (i == 0) begin
        if (first_exp >= 0) expq.push_back(first_exp);
      end else begin
        expq.push_back(gap);
      end
      tick(1'b1);
    end
  endtask

  task automatic check_loss(input string name, input int req);
`ifdef PULSE_CHK_STATS_EN
    check(name, int'(loss_count), req);
`endif
  endtask

  // Scoreboard monitor: every strobe must match the oldest queued period
  always @(negedge clk) begin
    if (!reset && period_valid) begin
      if (expq.size() == 0) begin
        n_checks++;
        $display("FAIL strobe_unexpected: got period=%0d, required no strobe", period);
      end else begin
        check("strobe_period", int'(period), expq.pop_front());
      end
    end
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "timeout");
  end

  initial begin
    reset      = 1'b1;
    en         = 1'b0;
    pulse_in   = 1'b0;
    err_clr    = 1'b0;
    exp_period = 8'd4;
    repeat (2) @(posedge clk);
    #1;
    check("rst_period", int'(period), 0);
    check("rst_valid", int'(period_valid), 0);
    check("rst_locked", int'(locked), 0);
    check("rst_err", int'(err), 0);
    check_loss("rst_loss", 0);
    reset = 1'b0;

    // Acquire lock with a pulse every 4 cycles
    en = 1'b1;
    pulses(4, 4, -1);
    check("pre_lock", int'(locked), 0);
    pulses(1, 4, 4);
    check("lock_5th", int'(locked), 1);
    check("lock_err", int'(err), 0);

    // Missing pulse: lock holds until the due slot goes empty
    repeat (3) tick(1'b0);
    check("miss_before", int'(locked), 1);
    tick(1'b0);
    check("miss_locked", int'(locked), 0);
    check("miss_err", int'(err), 1);
    check_loss("miss_loss", 1);

    // Relock from LOST; err stays sticky
    pulses(5, 4, -1);
    check("relock", int'(locked), 1);
    check("relock_err", int'(err), 1);

    // Disable while locked
    en = 1'b0;
    tick(1'b0);
    check("dis_locked", int'(locked), 0);
    check("dis_err", int'(err), 1);
    check("dis_period", int'(period), 4);
    en = 1'b1;

    // Relock from IDLE, then an early pulse with simultaneous err_clr
    pulses(5, 4, -1);
    check("relock2", int'(locked), 1);
    tick(1'b0);
    expq.push_back(2);
    err_clr = 1'b1;
    tick(1'b1);
    err_clr = 1'b0;
    check("early_locked", int'(locked), 0);
    check("early_err_setwins", int'(err), 1);
    check_loss("early_loss", 2);

    // Clear sticky error
    err_clr = 1'b1;
    tick(1'b0);
    err_clr = 1'b0;
    check("clr_err", int'(err), 0);
    check_loss("clr_loss", 0);

    // Wrong period: strobes of 3, never locks, no err
    pulses(6, 3, -1);
    check("p3_locked", int'(locked), 0);
    check("p3_err", int'(err), 0);

    // Silence: MEASURE times out to WAIT_FIRST without a strobe
    repeat (300) tick(1'b0);
    check("timeout_locked", int'(locked), 0);
    pulses(2, 5, -1);

    // Lock, lose via early pulse, relock, then reset mid-period
    pulses(4, 4, 4);
    check("lock3", int'(locked), 1);
    expq.push_back(1);
    tick(1'b1);
    check("early1_err", int'(err), 1);
    pulses(5, 4, -1);
    check("lock4", int'(locked), 1);
    check("lock4_period", int'(period), 4);
    tick(1'b0);
    reset = 1'b1;
    #2;
    check("arst_period", int'(period), 0);
    check("arst_valid", int'(period_valid), 0);
    check("arst_locked", int'(locked), 0);
    check("arst_err", int'(err), 0);
    check_loss("arst_loss", 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick(1'b0);
    check("queue_empty", expq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_pulse_period_checker
`default_nettype wire
